multiplier_8_bit: RTL and testbench

- Registered 8x8 unsigned integer multiplier producing a full-precision 16-bit product.
- Fully pipelined: accepts one operand pair per clock and delivers results at fixed latency with a valid flag.
- Used as the multiply primitive in the arithmetic/logic module set; feeds ALU/datapath blocks that need a full-width product.

---
 rtl/multiplier_8_bit.sv | 115 +++++++++++
 tb/tb_multiplier_8_bit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_8_bit.sv
// Two-stage pipelined 8x8 multiplier: operand registers, then a carry-save tree with a final adder.
// Define MULTIPLIER_SIGNED_EN for two's-complement operands via Baugh-Wooley partial products.
module multiplier_8_bit (
  input  logic        Clock_In,
  input  logic        Reset_n_In,
  input  logic        Valid_In,
  input  logic [7:0]  Data_A_In,
  input  logic [7:0]  Data_B_In,
  output logic        Valid_Out,
  output logic [15:0] Multiplied_Result_Out
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;

  typedef struct packed {
    logic [PROD_W-1:0] carry;
    logic [PROD_W-1:0] sum;
  } csa_t;

  // 3:2 compressor across the whole word; carries move up one weight.
  function automatic csa_t csa(input logic [PROD_W-1:0] x,
                               input logic [PROD_W-1:0] y,
                               input logic [PROD_W-1:0] z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              vld_p1;
  logic [PROD_W-1:0] pp_p1 [DATA_W];
  logic [DATA_W-1:0] row_p1;
  logic [PROD_W-1:0] corr_p1;
  logic [PROD_W-1:0] prod_p1;
  logic [PROD_W-1:0] result_p2;
  logic              vld_p2;

  // ---- stage 1: operand capture (data captured regardless of valid) ----
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      a_p1   <= '0;
      b_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      a_p1   <= Data_A_In;
      b_p1   <= Data_B_In;
      vld_p1 <= Valid_In;
    end
  end

  // ---- stage 2 combinational: partial products and reduction ----
  always_comb begin
    row_p1 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pp_p1[i] = '0;
    end
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < DATA_W; j++) begin
        row_p1[j] = a_p1[j] & b_p1[i];
`ifdef MULTIPLIER_SIGNED_EN
        // Terms pairing exactly one sign bit carry negative weight.
        if ((j == DATA_W - 1) != (i == DATA_W - 1)) begin
          row_p1[j] = ~row_p1[j];
        end
`endif
      end
      pp_p1[i] = {{DATA_W{1'b0}}, row_p1} << i;
    end
  end

`ifdef MULTIPLIER_SIGNED_EN
  // Baugh-Wooley correction: +2^n + 2^(2n-1).
  assign corr_p1 = PROD_W'((1 << DATA_W) | (1 << (PROD_W - 1)));
`else
  assign corr_p1 = '0;
`endif

  csa_t l1_0, l1_1, l1_2;
  csa_t l2_0, l2_1;
  csa_t l3_0;
  csa_t l4_0;

  assign l1_0 = csa(pp_p1[0], pp_p1[1], pp_p1[2]);
  assign l1_1 = csa(pp_p1[3], pp_p1[4], pp_p1[5]);
  assign l1_2 = csa(pp_p1[6], pp_p1[7], corr_p1);

  assign l2_0 = csa(l1_0.sum, l1_0.carry, l1_1.sum);
  assign l2_1 = csa(l1_1.carry, l1_2.sum, l1_2.carry);

  assign l3_0 = csa(l2_0.sum, l2_0.carry, l2_1.sum);
  assign l4_0 = csa(l3_0.sum, l3_0.carry, l2_1.carry);

  // Arithmetic is modulo 2^16, which is exact since every product fits.
  assign prod_p1 = l4_0.sum + l4_0.carry;

  // ---- stage 2 register: result loads only on a qualified operand pair ----
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      result_p2 <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= prod_p1;
      end
    end
  end

  assign Valid_Out             = vld_p2;
  assign Multiplied_Result_Out = result_p2;

endmodule

// File: tb/tb_multiplier_8_bit.sv
// Directed and streaming checks for multiplier_8_bit; signed vectors apply when MULTIPLIER_SIGNED_EN is defined.
module tb_multiplier_8_bit;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        valid_out;
  logic [15:0] result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] exp_q [$];

  multiplier_8_bit dut (
    .Clock_In              (clk),
    .Reset_n_In            (rst_n),
    .Valid_In              (valid_in),
    .Data_A_In             (a_in),
    .Data_B_In             (b_in),
    .Valid_Out             (valid_out),
    .Multiplied_Result_Out (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    valid_in = v;
    a_in     = a;
    b_in     = b;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef MULTIPLIER_SIGNED_EN
    logic signed [15:0] p;
    p = 16'($signed(a)) * 16'($signed(b));
    return p;
`else
    return {8'h00, a} * {8'h00, b};
`endif
  endfunction

  initial begin
`ifdef MULTIPLIER_SIGNED_EN
    vecs[0] = '{8'hFF, 8'h02, 16'hFFFE};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h80, 8'h7F, 16'hC080};
    vecs[3] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[4] = '{8'h00, 8'hA5, 16'h0000};
`else
    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h01, 8'hC3, 16'h00C3};
    vecs[4] = '{8'hC3, 8'h01, 16'h00C3};
`endif

    // Reset held with a valid operand pair present
    rst_n = 1'b0;
    drive(1'b1, 8'h12, 8'h34);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_vld", {15'd0, valid_out}, 16'h0000);
      check("rst_res", result, 16'h0000);
    end

    // Release: first product two edges after first sampled valid
    rst_n = 1'b1;
    tick();
    check("rel_vld_e1", {15'd0, valid_out}, 16'h0000);
    tick();
    check("rel_vld_e2", {15'd0, valid_out}, 16'h0001);
    check("rel_res", result, 16'h03A8);
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    check("idle_vld", {15'd0, valid_out}, 16'h0000);

    // Directed vectors
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].a, vecs[k].b);
      tick();
      drive(1'b0, 8'h5A, 8'hC3);
      check("dir_lat1", {15'd0, valid_out}, 16'h0000);
      tick();
      check("dir_vld", {15'd0, valid_out}, 16'h0001);
      check("dir_res", result, vecs[k].p);
    end
    tick();

    // Streaming back-to-back
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) begin
        logic [7:0] ra, rb;
        ra = 8'($urandom);
        rb = 8'($urandom);
        drive(1'b1, ra, rb);
        exp_q.push_back(ref_mul(ra, rb));
      end else begin
        drive(1'b0, 8'h00, 8'h00);
      end
      tick();
      if (c >= 1) begin
        check("strm_vld", {15'd0, valid_out}, 16'h0001);
        check("strm_res", result, exp_q.pop_front());
      end
    end
    tick();
    check("strm_end_vld", {15'd0, valid_out}, 16'h0000);

    // Bubble: valid, invalid, valid
    drive(1'b1, 8'h0F, 8'h0F);
    tick();
    drive(1'b0, 8'hAA, 8'h55);
    tick();
    check("bub_vld0", {15'd0, valid_out}, 16'h0001);
    check("bub_res0", result, 16'h00E1);
    drive(1'b1, 8'h03, 8'h05);
    tick();
    check("bub_vld1", {15'd0, valid_out}, 16'h0000);
    check("bub_hold", result, 16'h00E1);
    drive(1'b0, 8'h00, 8'h00);
    tick();
    check("bub_vld2", {15'd0, valid_out}, 16'h0001);
    check("bub_res2", result, 16'h000F);

    // Reset mid-stream with a product in flight
    drive(1'b1, 8'h10, 8'h10);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {15'd0, valid_out}, 16'h0000);
    check("mid_rst_res", result, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_vld1", {15'd0, valid_out}, 16'h0000);
    tick();
    check("post_rst_vld2", {15'd0, valid_out}, 16'h0000);
    check("post_rst_res", result, 16'h0000);
    drive(1'b1, 8'h02, 8'h03);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    check("post_lat1", {15'd0, valid_out}, 16'h0000);
    tick();
    check("post_vld", {15'd0, valid_out}, 16'h0001);
    check("post_res", result, 16'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
